// File: rtl/mdu_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_controller : EX-stage multiply/divide unit, busy sequencer and HI/LO.
// Optional madd/maddu decode enabled by defining MDU_MADD_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module mdu_controller #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_IFID,
  input  logic [31:0] IR_IDEX,
  input  logic [31:0] RS_E,
  input  logic [31:0] RT_E,
  input  logic        cancel_E,
  output logic        start,
  output logic        busy,
  output logic        stall_MD,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic [31:0] MD_out
);

  localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  function automatic logic is_mdu(input logic [31:0] ir);
    logic hit;
    hit = (ir[31:26] == 6'b000000) &&
          ((ir[5:2] == 4'b0100) || (ir[5:2] == 4'b0110));
`ifdef MDU_MADD_EN
    hit = hit || ((ir[31:26] == 6'b011100) && (ir[5:1] == 5'b00000));
`endif
    return hit;
  endfunction

  logic ex_special, ex_mult, ex_multu, ex_div, ex_divu;
  logic ex_mfhi, ex_mthi, ex_mflo, ex_mtlo, ex_madd, ex_maddu, ex_is_div;

  assign ex_special = (IR_IDEX[31:26] == 6'b000000);
  assign ex_mult    = ex_special && (IR_IDEX[5:0] == 6'b011000);
  assign ex_multu   = ex_special && (IR_IDEX[5:0] == 6'b011001);
  assign ex_div     = ex_special && (IR_IDEX[5:0] == 6'b011010);
  assign ex_divu    = ex_special && (IR_IDEX[5:0] == 6'b011011);
  assign ex_mfhi    = ex_special && (IR_IDEX[5:0] == 6'b010000);
  assign ex_mthi    = ex_special && (IR_IDEX[5:0] == 6'b010001);
  assign ex_mflo    = ex_special && (IR_IDEX[5:0] == 6'b010010);
  assign ex_mtlo    = ex_special && (IR_IDEX[5:0] == 6'b010011);
`ifdef MDU_MADD_EN
  assign ex_madd    = (IR_IDEX[31:26] == 6'b011100) && (IR_IDEX[5:0] == 6'b000000);
  assign ex_maddu   = (IR_IDEX[31:26] == 6'b011100) && (IR_IDEX[5:0] == 6'b000001);
`else
  assign ex_madd    = 1'b0;
  assign ex_maddu   = 1'b0;
`endif
  assign ex_is_div  = ex_div || ex_divu;

  assign start = !cancel_E &&
                 (ex_mult || ex_multu || ex_div || ex_divu || ex_madd || ex_maddu);

  logic [63:0] prod, mac;
  logic [31:0] num_mag, den_mag, den_safe, q_mag, r_mag, quo, rem;
  logic        mul_signed;

  always_comb begin
    mul_signed = ex_mult || ex_madd;
    if (mul_signed)
      prod = {{32{RS_E[31]}}, RS_E} * {{32{RT_E[31]}}, RT_E};
    else
      prod = {32'd0, RS_E} * {32'd0, RT_E};
    mac = {hi_q, lo_q} + prod;

    // Signed divide works on magnitudes; this also yields 0x80000000 / -1 = 0x80000000.
    num_mag  = (ex_div && RS_E[31]) ? (32'd0 - RS_E) : RS_E;
    den_mag  = (ex_div && RT_E[31]) ? (32'd0 - RT_E) : RT_E;
    den_safe = (den_mag == 32'd0) ? 32'd1 : den_mag;
    q_mag    = num_mag / den_safe;
    r_mag    = num_mag % den_safe;
    quo      = (ex_div && (RS_E[31] ^ RT_E[31])) ? (32'd0 - q_mag) : q_mag;
    rem      = (ex_div && RS_E[31]) ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    if (!cancel_E && ex_mthi) hi_d = RS_E;
    if (!cancel_E && ex_mtlo) lo_d = RS_E;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = BUSY;
          cnt_d     = ex_is_div ? DIV_CNT : MULT_CNT;
          pend_wr_d = !(ex_is_div && (RT_E == 32'd0));
          if (ex_is_div) begin
            pend_hi_d = rem;
            pend_lo_d = quo;
          end else if (ex_madd || ex_maddu) begin
            pend_hi_d = mac[63:32];
            pend_lo_d = mac[31:0];
          end else begin
            pend_hi_d = prod[63:32];
            pend_lo_d = prod[31:0];
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign stall_MD = is_mdu(IR_IFID) && (start || busy);
  assign HI_out   = hi_q;
  assign LO_out   = lo_q;
  assign MD_out   = ex_mfhi ? hi_q : (ex_mflo ? lo_q : 32'd0);

  logic unused_bits;
  assign unused_bits = ^{IR_IDEX[25:6], IR_IFID[25:6]};

endmodule
`default_nettype wire

// File: tb/tb_mdu_controller.sv
`default_nettype none
// tb_mdu_controller : randomized scoreboard bench; a behavioural HI/LO model
// feeds expected commits and mfhi/mflo reads to a negedge monitor.
module tb_mdu_controller;

  localparam int OP_MULT = 0, OP_MULTU = 1, OP_DIV = 2, OP_DIVU = 3;
  localparam int OP_MTHI = 4, OP_MTLO = 5, OP_MFHI = 6, OP_MFLO = 7;
  localparam int OP_MADDU = 8, OP_NOP = 9, OP_ADDU = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk, reset, cancel_E;
  logic [31:0] IR_IFID, IR_IDEX, RS_E, RT_E;
  logic        start, busy, stall_MD;
  logic [31:0] HI_out, LO_out, MD_out;

  mdu_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .IR_IFID(IR_IFID), .IR_IDEX(IR_IDEX),
    .RS_E(RS_E), .RT_E(RT_E), .cancel_E(cancel_E), .start(start),
    .busy(busy), .stall_MD(stall_MD), .HI_out(HI_out), .LO_out(LO_out),
    .MD_out(MD_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi = 32'd0, mlo = 32'd0;
  logic [63:0] q_commit[$];
  logic [31:0] q_md[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op);
    case (op)
      OP_MULT:  return {6'd0, 5'd4, 5'd5, 10'd0, 6'b011000};
      OP_MULTU: return {6'd0, 5'd4, 5'd5, 10'd0, 6'b011001};
      OP_DIV:   return {6'd0, 5'd4, 5'd5, 10'd0, 6'b011010};
      OP_DIVU:  return {6'd0, 5'd4, 5'd5, 10'd0, 6'b011011};
      OP_MTHI:  return {6'd0, 5'd4, 15'd0, 6'b010001};
      OP_MTLO:  return {6'd0, 5'd4, 15'd0, 6'b010011};
      OP_MFHI:  return {6'd0, 10'd0, 5'd2, 5'd0, 6'b010000};
      OP_MFLO:  return {6'd0, 10'd0, 5'd2, 5'd0, 6'b010010};
      OP_MADDU: return {6'b011100, 5'd4, 5'd5, 10'd0, 6'b000001};
      OP_ADDU:  return {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100001};
      default:  return 32'd0;
    endcase
  endfunction

  // Monitor: a busy 1->0 transition is a commit; mfhi/mflo in EX is a read.
  logic        prev_busy = 1'b0;
  logic [63:0] mon_e;
  logic [31:0] mon_md;
  always @(negedge clk) begin
    if (!reset) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (q_commit.size() == 0) chk("unexpected commit", 64'd1, 64'd0);
        else begin
          mon_e = q_commit.pop_front();
          chk("commit HI:LO", {HI_out, LO_out}, mon_e);
        end
      end
      if (IR_IDEX == enc(OP_MFHI) || IR_IDEX == enc(OP_MFLO)) begin
        if (q_md.size() == 0) chk("unexpected mf read", 64'd1, 64'd0);
        else begin
          mon_md = q_md.pop_front();
          chk("MD_out", {32'd0, MD_out}, {32'd0, mon_md});
        end
      end
      prev_busy = busy;
    end
  end

  // Issue one instruction into EX (with id_ir in ID), update the model,
  // then follow it through until the unit is idle again.
  task automatic do_op(input int op, input logic [31:0] rs, input logic [31:0] rt,
                       input bit cxl, input logic [31:0] id_ir);
    logic        st;
    int          exp_b, exp_s, nb, ns;
    logic [63:0] hl;
    longint      sa, sb;
    st    = !cxl && (op <= OP_DIVU || (op == OP_MADDU && MADD_EN));
    exp_b = !st ? 0 : ((op == OP_DIV || op == OP_DIVU) ? 10 : 5);
    exp_s = (st && (id_ir == enc(OP_MFLO) || id_ir == enc(OP_MFHI))) ? exp_b + 1 : 0;
    hl    = {mhi, mlo};
    if (!cxl) begin
      case (op)
        OP_MULT:  hl = 64'(longint'($signed(rs)) * longint'($signed(rt)));
        OP_MULTU: hl = {32'd0, rs} * {32'd0, rt};
        OP_MADDU: if (MADD_EN) hl = {mhi, mlo} + {32'd0, rs} * {32'd0, rt};
        OP_DIV: if (rt != 32'd0) begin
          sa = longint'($signed(rs));
          sb = longint'($signed(rt));
          hl = {32'(sa % sb), 32'(sa / sb)};
        end
        OP_DIVU: if (rt != 32'd0) hl = {rs % rt, rs / rt};
        OP_MTHI: mhi = rs;
        OP_MTLO: mlo = rs;
        default: ;
      endcase
    end
    if (st) begin
      q_commit.push_back(hl);
      {mhi, mlo} = hl;
    end
    if (op == OP_MFHI) q_md.push_back(mhi);
    if (op == OP_MFLO) q_md.push_back(mlo);

    IR_IDEX = enc(op); RS_E = rs; RT_E = rt; cancel_E = cxl; IR_IFID = id_ir;
    @(negedge clk);
    chk("start", {63'd0, start}, {63'd0, st});
    ns = stall_MD ? 1 : 0;
    nb = 0;
    @(posedge clk); #1;
    IR_IDEX = enc(OP_NOP); cancel_E = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (stall_MD) ns++;
      if (!busy) break;
      nb++;
    end
    chk("busy cycles", 64'(nb), 64'(exp_b));
    chk("stall cycles", 64'(ns), 64'(exp_s));
    @(posedge clk); #1;
    IR_IFID = enc(OP_NOP);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rs, rt, idr;
    int          op;
    bit          cx;
    reset = 1'b0; cancel_E = 1'b0; RS_E = 32'd0; RT_E = 32'd0;
    IR_IDEX = enc(OP_NOP); IR_IFID = enc(OP_NOP);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset HI:LO", {HI_out, LO_out}, 64'd0);
    @(posedge clk); #1;

    // Reset in the middle of a div discards it and clears HI/LO.
    do_op(OP_MTHI, 32'h0000AAAA, 32'd0, 1'b0, enc(OP_NOP));
    IR_IDEX = enc(OP_DIV); RS_E = 32'd100; RT_E = 32'd3;
    @(posedge clk); #1 IR_IDEX = enc(OP_NOP);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; IR_IFID = enc(OP_MFLO);
    mhi = 32'd0; mlo = 32'd0;
    @(negedge clk);
    chk("post-reset busy", {63'd0, busy}, 64'd0);
    chk("post-reset HI:LO", {HI_out, LO_out}, 64'd0);
    chk("post-reset stall", {63'd0, stall_MD}, 64'd0);
    @(posedge clk); #1 IR_IFID = enc(OP_NOP);

    do_op(OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, enc(OP_NOP));
    chk("mult vector", {HI_out, LO_out}, 64'hFFFFFFFF_FFFFFFFE);
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, enc(OP_NOP));
    chk("multu vector", {HI_out, LO_out}, 64'h00000001_FFFFFFFE);
    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, enc(OP_MFLO));
    chk("div vector", {HI_out, LO_out}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(OP_MFLO, 32'd0, 32'd0, 1'b0, enc(OP_NOP));
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, enc(OP_NOP));
    chk("div overflow vector", {HI_out, LO_out}, 64'h00000000_80000000);

    do_op(OP_MTHI, 32'h00001234, 32'd0, 1'b0, enc(OP_NOP));
    do_op(OP_MTLO, 32'h00005678, 32'd0, 1'b0, enc(OP_NOP));
    do_op(OP_DIVU, 32'h00000077, 32'd0, 1'b0, enc(OP_NOP));
    chk("divu by zero keeps", {HI_out, LO_out}, 64'h00001234_00005678);
    do_op(OP_MFHI, 32'd0, 32'd0, 1'b0, enc(OP_NOP));

    do_op(OP_MULT, 32'd7, 32'd9, 1'b1, enc(OP_MFLO));
    do_op(OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b1, enc(OP_NOP));
    chk("cancel keeps HI:LO", {HI_out, LO_out}, 64'h00001234_00005678);
    do_op(OP_MULT, 32'd3, 32'd5, 1'b0, enc(OP_ADDU));

    do_op(OP_MTHI, 32'd0, 32'd0, 1'b0, enc(OP_NOP));
    do_op(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0, enc(OP_NOP));
    do_op(OP_MADDU, 32'd1, 32'd1, 1'b0, enc(OP_MFHI));
    chk("maddu vector", {HI_out, LO_out},
        MADD_EN ? 64'h00000001_00000000 : 64'h00000000_FFFFFFFF);
    do_op(OP_MFLO, 32'd0, 32'd0, 1'b0, enc(OP_NOP));

    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 7));
      rs = $urandom;
      rt = $urandom;
      case ($urandom_range(0, 15))
        0, 1: rt = 32'd0;
        2: begin rs = 32'h80000000; rt = 32'hFFFFFFFF; end
        3: rt = 32'($urandom_range(1, 9));
        default: ;
      endcase
      cx  = (op < OP_MFHI) && ($urandom_range(0, 7) == 0);
      idr = $urandom_range(0, 1) ? enc(OP_MFLO) : enc(OP_ADDU);
      do_op(op, rs, rt, cx, idr);
    end
    do_op(OP_MFHI, 32'd0, 32'd0, 1'b0, enc(OP_NOP));
    do_op(OP_MFLO, 32'd0, 32'd0, 1'b0, enc(OP_NOP));

    repeat (3) @(negedge clk);
    chk("commit queue drained", 64'(q_commit.size()), 64'd0);
    chk("md queue drained", 64'(q_md.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
